// File: rtl/dds_sample_gen.sv
// Direct digital synthesis sample generator producing saw/square/triangle/sine samples on a divided tick.
// Define DDS_SINE_LUT_EN to build the quarter-wave sine table; otherwise waveform 11 falls back to triangle.
module dds_sample_gen #(
  parameter int PHASE_W = 24,
  parameter int DIV     = 240
) (
  input  logic       Fg_CLK,
  input  logic       RESETn,
  input  logic       Enable,
  input  logic       Ready,
  input  logic [3:0] Mode,
  output logic [7:0] Sample,
  output logic       SampleValid,
  output logic       Running
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state, state_next;
  logic [PHASE_W-1:0] phase, tuning_word;
  logic [PHASE_W:0]   phase_sum;
  logic [CNT_W-1:0]   tick_cnt;
  logic [3:0]         mode_q;
  logic               pending, start, advance, tick, emit;
  logic [7:0]         p, tri_val, wave;

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_next;
  end

  // Enable=0 leaves RUN/HOLD before any Ready-driven transition is considered
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Enable && Ready) state_next = RUN;
      RUN:     if (!Enable) state_next = IDLE;
               else if (!Ready) state_next = HOLD;
      HOLD:    if (!Enable) state_next = IDLE;
               else if (Ready) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign Running = (state != IDLE);
  assign start   = (state == IDLE) && Enable && Ready;
  assign advance = (state == RUN) && Enable && Ready;
  assign tick    = advance && (tick_cnt == CNT_LAST);
  assign emit    = advance && pending;

  always_comb begin
    tuning_word = PHASE_W'(167772);
    case (mode_q[3:2])
      2'b00: tuning_word = PHASE_W'(167772);
      2'b01: tuning_word = PHASE_W'(335544);
      2'b10: tuning_word = PHASE_W'(838861);
      2'b11: tuning_word = PHASE_W'(1677722);
      default: tuning_word = PHASE_W'(167772);
    endcase
  end

  assign phase_sum = {1'b0, phase} + {1'b0, tuning_word};
  assign p         = phase[PHASE_W-1 -: 8];
  assign tri_val   = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};

`ifdef DDS_SINE_LUT_EN
  // round(127*sin(2*pi*i/256)) for i = 0..63
  localparam logic [6:0] SINE_Q [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };
  logic [5:0] sine_idx;
  logic [6:0] sine_mag;
  assign sine_idx = p[6] ? ~p[5:0] : p[5:0];
  assign sine_mag = SINE_Q[sine_idx];
`endif

  always_comb begin
    wave = p;
    case (mode_q[1:0])
      2'b00: wave = p;
      2'b01: wave = {8{p[7]}};
      2'b10: wave = tri_val;
`ifdef DDS_SINE_LUT_EN
      2'b11: wave = p[7] ? (8'd128 - {1'b0, sine_mag}) : (8'd128 + {1'b0, sine_mag});
`else
      2'b11: wave = tri_val;
`endif
      default: wave = p;
    endcase
  end

  // A new Mode is only accepted on a tick whose add wraps the accumulator, so waveforms change glitch-free
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      phase       <= '0;
      tick_cnt    <= '0;
      mode_q      <= '0;
      pending     <= 1'b0;
      Sample      <= 8'h80;
      SampleValid <= 1'b0;
    end else begin
      SampleValid <= emit;
      if (start) begin
        phase    <= '0;
        tick_cnt <= '0;
        mode_q   <= Mode;
        pending  <= 1'b0;
      end else if (advance) begin
        pending <= tick;
        if (tick) begin
          tick_cnt <= '0;
          phase    <= phase_sum[PHASE_W-1:0];
          if (phase_sum[PHASE_W]) mode_q <= Mode;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
      if (state_next == IDLE) Sample <= 8'h80;
      else if (emit)          Sample <= wave;
    end
  end

endmodule
